// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port text/attribute RAM between the video
// fetch (absolute priority, zero added latency) and the CPU bus (scheduled
// into free cycles through a one-entry posted-write buffer).
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   vid_req/vid_addr  video owns the RAM this cycle / its read address
//   vid_data          RAM read data, straight from ram_rdata
//   vid_valid         registered copy of vid_req (data valid this cycle)
//   cpu_req/cpu_we    CPU request level and direction
//   cpu_addr/wdata    CPU address and write data, stable while cpu_req=1
//   cpu_rdata         registered read data, valid with cpu_ready
//   cpu_ready         one-cycle completion pulse
//   ram_*             RAM address/write-data/write-enable (combinational)
//   ram_rdata         RAM read data, one cycle after the address
module vram_arbiter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          vid_valid_q;
    logic          cpu_ready_q, cpu_ready_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          retire_c;

    // Buffered write drains on any cycle the video fetch leaves the RAM free.
    assign retire_c = wb_valid_q & ~vid_req;

    // RAM port owner: video, then write-buffer retire, then CPU address.
    always_comb begin
        ram_address = cpu_addr;
        ram_wdata   = wb_data_q;
        ram_we      = 1'b0;
        if (vid_req) begin
            ram_address = vid_addr;
        end else if (wb_valid_q) begin
            ram_address = wb_addr_q;
            ram_we      = 1'b1;
        end
    end

    // Video sees the RAM directly; only the valid strobe is registered.
    assign vid_data  = ram_rdata;
    assign vid_valid = vid_valid_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;

    // CPU access sequencing and write-buffer management.
    always_comb begin
        state_d     = state_q;
        wb_valid_d  = wb_valid_q & ~retire_c;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        // Buffer is free now or frees at this edge.
                        if (!wb_valid_q || retire_c) begin
                            wb_valid_d  = 1'b1;
                            wb_addr_d   = cpu_addr;
                            wb_data_d   = cpu_wdata;
                            cpu_ready_d = 1'b1;
                            state_d     = DONE;
                        end
                    end else if (wb_valid_q && (wb_addr_q == cpu_addr)) begin
                        // Read hits the pending write: answer from the buffer.
                        cpu_rdata_d = wb_data_q;
                        cpu_ready_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                // Reads never pass a buffered write.
                if (!vid_req && !wb_valid_q) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                cpu_rdata_d = ram_rdata;
                cpu_ready_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            vid_valid_q <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            vid_valid_q <= vid_req;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [11:0] ram_address;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        mem_init;
    logic [7:0]  mem [0:4095];

    int n_cmp = 0;
    int n_err = 0;

    vram_arbiter #(.AW(12), .DW(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data),
        .vid_valid   (vid_valid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM; mem_init clears it and loads the known bytes.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h0A0] <= 8'h41;
            mem[12'h0A1] <= 8'h17;
            mem[12'h010] <= 8'h5C;
            mem[12'h011] <= 8'h99;
            ram_rdata    <= 8'h00;
        end else begin
            if (ram_we) mem[ram_address] <= ram_wdata;
            ram_rdata <= mem[ram_address];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vr;
        logic [11:0] va;
        logic        cr;
        logic        cwe;
        logic [11:0] ca;
        logic [7:0]  cd;
        logic [11:0] ea;
        logic        ewe;
        logic [7:0]  ewd;
        logic        erdy;
        logic        chkrd;
        logic [7:0]  erd;
        logic        evv;
        logic [7:0]  evd;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(
        input logic vr, input logic [11:0] va, input logic cr, input logic cwe,
        input logic [11:0] ca, input logic [7:0] cd, input logic [11:0] ea,
        input logic ewe, input logic [7:0] ewd, input logic erdy, input logic chkrd,
        input logic [7:0] erd, input logic evv, input logic [7:0] evd);
        vec_t v;
        v.vr = vr; v.va = va; v.cr = cr; v.cwe = cwe; v.ca = ca; v.cd = cd;
        v.ea = ea; v.ewe = ewe; v.ewd = ewd; v.erdy = erdy; v.chkrd = chkrd;
        v.erd = erd; v.evv = evv; v.evd = evd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vr, input logic [11:0] va, input logic cr,
                         input logic cwe, input logic [11:0] ca, input logic [7:0] cd);
        vid_req = vr; vid_addr = va; cpu_req = cr; cpu_we = cwe;
        cpu_addr = ca; cpu_wdata = cd;
    endtask

    // Uncontended CPU read from IDLE: ready expected 3 cycles after the request.
    task automatic cpu_read(input logic [11:0] a, input logic [7:0] exp);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        drive(1'b0, 12'h000, 1'b1, 1'b0, a, 8'h00);
        while (!seen && n < 10) begin
            @(negedge clock);
            n++;
            if (cpu_ready) seen = 1;
        end
        chk($sformatf("read 0x%03h ready seen", a), 32'(seen), 32'd1);
        if (seen) begin
            chk($sformatf("read 0x%03h latency", a), 32'(n), 32'd3);
            chk($sformatf("read 0x%03h data", a), 32'(cpu_rdata), 32'(exp));
        end
        cpu_req = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic        pvr;
        logic [11:0] pva;
        logic        vr;
        logic [11:0] va;
        int          wcount;
        bit          got;

        reset = 1'b1;
        mem_init = 1'b1;
        drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
        repeat (3) @(negedge clock);
        chk("reset cpu_ready", 32'(cpu_ready), 32'd0);
        chk("reset vid_valid", 32'(vid_valid), 32'd0);
        chk("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("reset ram_we", 32'(ram_we), 32'd0);
        mem_init = 1'b0;
        reset = 1'b0;
        @(negedge clock);

        cpu_read(12'h0A1, 8'h17);

        // Read interrupted by reset while in RD_WAIT.
        drive(1'b0, 12'h000, 1'b1, 1'b0, 12'h0A0, 8'h00);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
        #1;
        chk("rst rdwait cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst rdwait cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst rdwait vid_valid", 32'(vid_valid), 32'd0);
        chk("rst rdwait ram_we", 32'(ram_we), 32'd0);
        chk("rst rdwait ram_address", 32'(ram_address), 32'h000);
        repeat (2) begin
            @(negedge clock);
            chk("rst hold cpu_ready", 32'(cpu_ready), 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);
        chk("post rst cpu_ready", 32'(cpu_ready), 32'd0);
        chk("post rst ram_we", 32'(ram_we), 32'd0);
        cpu_read(12'h0A0, 8'h41);

        // Buffered write discarded by reset before it retires.
        drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h0A0, 8'hFF);
        @(negedge clock);
        chk("rst wb accepted", 32'(cpu_ready), 32'd1);
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("rst wb ram_we", 32'(ram_we), 32'd0);
        chk("rst wb cpu_ready", 32'(cpu_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst wb discarded ram_we", 32'(ram_we), 32'd0);
        cpu_read(12'h0A0, 8'h41);

        // Video strobes at phases 0 and 4 of every 8 cycles, no CPU traffic.
        pvr = 1'b0;
        pva = 12'h000;
        for (int k = 0; k < 16; k++) begin
            vr = ((k % 8) == 0) || ((k % 8) == 4);
            va = ((k % 8) == 0) ? 12'h0A0 : 12'h0A1;
            vec.push_back(mk(vr, va, 1'b0, 1'b0, 12'h000, 8'h00,
                             vr ? va : 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,
                             pvr, (pva == 12'h0A0) ? 8'h41 : 8'h17));
            pvr = vr;
            pva = va;
        end
        // Write 0x123<-0x5A, retire next cycle, read back.
        vec.push_back(mk(0, 12'h000, 1, 1, 12'h123, 8'h5A, 12'h123, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 0, 0, 12'h123, 8'h00, 12'h123, 1, 8'h5A, 1, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 1, 0, 12'h123, 8'h00, 12'h123, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 1, 0, 12'h123, 8'h00, 12'h123, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 1, 0, 12'h123, 8'h00, 12'h123, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 0, 0, 12'h123, 8'h00, 12'h123, 0, 8'h00, 1, 1, 8'h5A, 0, 8'h00));
        // Write 0x300<-0xC3, video holds the buffer, read 0x300 is forwarded.
        vec.push_back(mk(0, 12'h000, 1, 1, 12'h300, 8'hC3, 12'h300, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(1, 12'h0A0, 0, 0, 12'h300, 8'h00, 12'h0A0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 1, 0, 12'h300, 8'h00, 12'h300, 1, 8'hC3, 0, 0, 8'h00, 1, 8'h41));
        vec.push_back(mk(0, 12'h000, 0, 0, 12'h300, 8'h00, 12'h300, 0, 8'h00, 1, 1, 8'hC3, 0, 8'h00));
        // Write 0x010; two back-to-back video cycles keep it buffered so the
        // read of 0x011 waits in RD_ISSUE for the retire.
        vec.push_back(mk(0, 12'h000, 1, 1, 12'h010, 8'hE7, 12'h010, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(1, 12'h0A1, 0, 0, 12'h010, 8'h00, 12'h0A1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(1, 12'h0A0, 1, 0, 12'h011, 8'h00, 12'h0A0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h17));
        vec.push_back(mk(0, 12'h000, 1, 0, 12'h011, 8'h00, 12'h010, 1, 8'hE7, 0, 0, 8'h00, 1, 8'h41));
        vec.push_back(mk(0, 12'h000, 1, 0, 12'h011, 8'h00, 12'h011, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 1, 0, 12'h011, 8'h00, 12'h011, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 0, 0, 12'h011, 8'h00, 12'h011, 0, 8'h00, 1, 1, 8'h99, 0, 8'h00));
        // Read 0x0A1 stalled once by video in RD_ISSUE, video again in RD_WAIT.
        vec.push_back(mk(0, 12'h000, 1, 0, 12'h0A1, 8'h00, 12'h0A1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(1, 12'h0A0, 1, 0, 12'h0A1, 8'h00, 12'h0A0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 1, 0, 12'h0A1, 8'h00, 12'h0A1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h41));
        vec.push_back(mk(1, 12'h0A0, 1, 0, 12'h0A1, 8'h00, 12'h0A0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 0, 0, 12'h0A1, 8'h00, 12'h0A1, 0, 8'h00, 1, 1, 8'h17, 1, 8'h41));
        // Second write accepted in the same cycle the first one retires.
        vec.push_back(mk(0, 12'h000, 1, 1, 12'h200, 8'h11, 12'h200, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(1, 12'h0A1, 0, 0, 12'h200, 8'h00, 12'h0A1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 1, 1, 12'h201, 8'h22, 12'h200, 1, 8'h11, 0, 0, 8'h00, 1, 8'h17));
        vec.push_back(mk(0, 12'h000, 0, 0, 12'h201, 8'h00, 12'h201, 1, 8'h22, 1, 0, 8'h00, 0, 8'h00));
        vec.push_back(mk(0, 12'h000, 0, 0, 12'h000, 8'h00, 12'h000, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));

        foreach (vec[i]) begin
            drive(vec[i].vr, vec[i].va, vec[i].cr, vec[i].cwe, vec[i].ca, vec[i].cd);
            #1;
            chk($sformatf("row%0d ram_address", i), 32'(ram_address), 32'(vec[i].ea));
            chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(vec[i].ewe));
            if (vec[i].ewe) chk($sformatf("row%0d ram_wdata", i), 32'(ram_wdata), 32'(vec[i].ewd));
            chk($sformatf("row%0d cpu_ready", i), 32'(cpu_ready), 32'(vec[i].erdy));
            if (vec[i].chkrd) chk($sformatf("row%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vec[i].erd));
            chk($sformatf("row%0d vid_valid", i), 32'(vid_valid), 32'(vec[i].evv));
            if (vec[i].evv) chk($sformatf("row%0d vid_data", i), 32'(vid_data), 32'(vec[i].evd));
            @(negedge clock);
        end

        // Write 0x200<-0xA5 against video every other cycle: the retire must
        // fall on a free cycle and never replace a video address.
        wcount = 0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            vr = ((c % 2) == 1);
            va = ((c % 4) == 1) ? 12'h0A0 : 12'h0A1;
            drive(vr, va, !got, 1'b1, 12'h200, 8'hA5);
            #1;
            if (vr) begin
                chk($sformatf("vid c%0d ram_address", c), 32'(ram_address), 32'(va));
                chk($sformatf("vid c%0d ram_we", c), 32'(ram_we), 32'd0);
            end
            if (ram_we) begin
                wcount++;
                chk($sformatf("retire c%0d on vid cycle", c), 32'(vr), 32'd0);
                chk($sformatf("retire c%0d ram_address", c), 32'(ram_address), 32'h200);
                chk($sformatf("retire c%0d ram_wdata", c), 32'(ram_wdata), 32'hA5);
            end
            @(negedge clock);
            if (cpu_ready) got = 1;
        end
        chk("wr 0x200 ready seen", 32'(got), 32'd1);
        chk("wr 0x200 retire count", 32'(wcount), 32'd1);
        drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
        @(negedge clock);

        cpu_read(12'h200, 8'hA5);
        cpu_read(12'h201, 8'h22);
        cpu_read(12'h010, 8'hE7);
        cpu_read(12'h300, 8'hC3);
        cpu_read(12'h123, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
